// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : vga_pattern_gen_if                                             |
// | Brief    : Start/pattern-select and write-data bundle of vga_pattern_gen. |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
interface vga_pattern_gen_if #(
  parameter int DATA_W = 16
);
  logic              start_i;
  logic [1:0]        mode_i;
  logic [15:0]       color_i;
  logic              wr_en;
  logic              data_en;
  logic [DATA_W-1:0] dout;
  logic              busy_o;
  logic              frame_done_o;

  // master: the arbiter side requesting frames; slave: the generator
  modport master (
    output start_i, mode_i, color_i, wr_en,
    input  data_en, dout, busy_o, frame_done_o
  );

  modport slave (
    input  start_i, mode_i, color_i, wr_en,
    output data_en, dout, busy_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : vga_pattern_gen                                                |
// | Brief    : Raster-order RGB565 frame writer with four test patterns.      |
// |            Define VGA_PATTERN_SCROLL_EN to scroll patterns one pixel/frame.|
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module vga_pattern_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768,
  parameter int DATA_W    = 16,
  parameter int CHK_SHIFT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int c_XW    = $clog2(H_ACTIVE);
  localparam int c_YW    = $clog2(V_ACTIVE);
  localparam int c_BAR_W = H_ACTIVE / 8;
  localparam int c_BW    = $clog2(c_BAR_W);

  localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(H_ACTIVE - 1);
  localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(V_ACTIVE - 1);
  localparam logic [c_BW-1:0] c_BAR_LAST = c_BW'(c_BAR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_XW-1:0]   r_x, w_x_nxt;
  logic [c_YW-1:0]   r_y, w_y_nxt;
  logic [2:0]        r_bar_idx, w_bar_idx_nxt;
  logic [c_BW-1:0]   r_bar_off, w_bar_off_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [15:0]       r_color, w_color_nxt;
  logic              r_data_en, w_data_en_nxt;
  logic [DATA_W-1:0] r_dout, w_dout_nxt;
  logic              r_frame_done, w_frame_done_nxt;

  logic [c_XW-1:0]   w_xe;
  logic [c_XW-1:0]   w_pre_x;
  logic [2:0]        w_pre_idx;
  logic [c_BW-1:0]   w_pre_off;
  logic [5:0]        w_ramp_v;
  logic [15:0]       w_bar_rgb;
  logic [15:0]       w_pix;
  logic              w_chk_x, w_chk_y;

`ifdef VGA_PATTERN_SCROLL_EN
  // Scroll offset is kept as a running (x, bar index, bar offset) triple so
  // that frame_cnt mod H_ACTIVE never needs a divider.
  logic [7:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic [c_XW-1:0]   r_sc_x, w_sc_x_nxt;
  logic [2:0]        r_sc_idx, w_sc_idx_nxt;
  logic [c_BW-1:0]   r_sc_off, w_sc_off_nxt;
  logic [c_XW-1:0]   r_xe, w_xe_nxt;

  assign w_xe      = r_xe;
  assign w_pre_x   = r_sc_x;
  assign w_pre_idx = r_sc_idx;
  assign w_pre_off = r_sc_off;

  always_comb begin
    w_frame_cnt_nxt = r_frame_cnt;
    w_sc_x_nxt      = r_sc_x;
    w_sc_idx_nxt    = r_sc_idx;
    w_sc_off_nxt    = r_sc_off;
    if (r_state == S_DONE) begin
      w_frame_cnt_nxt = r_frame_cnt + 8'd1;
      if (r_frame_cnt == 8'hFF || r_sc_x == c_X_LAST) begin
        w_sc_x_nxt   = '0;
        w_sc_idx_nxt = '0;
        w_sc_off_nxt = '0;
      end else begin
        w_sc_x_nxt = r_sc_x + 1'b1;
        if (r_sc_off == c_BAR_LAST) begin
          w_sc_off_nxt = '0;
          w_sc_idx_nxt = r_sc_idx + 3'd1;
        end else begin
          w_sc_off_nxt = r_sc_off + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_sc_x      <= '0;
      r_sc_idx    <= '0;
      r_sc_off    <= '0;
      r_xe        <= '0;
    end else begin
      r_frame_cnt <= w_frame_cnt_nxt;
      r_sc_x      <= w_sc_x_nxt;
      r_sc_idx    <= w_sc_idx_nxt;
      r_sc_off    <= w_sc_off_nxt;
      r_xe        <= w_xe_nxt;
    end
  end
`else
  assign w_xe      = r_x;
  assign w_pre_x   = '0;
  assign w_pre_idx = '0;
  assign w_pre_off = '0;
`endif

  generate
    if (c_XW >= 6) begin : g_ramp_wide
      assign w_ramp_v = w_xe[c_XW-1 -: 6];
    end else begin : g_ramp_narrow
      assign w_ramp_v = {w_xe, {(6-c_XW){1'b0}}};
    end

    if (CHK_SHIFT < c_XW) begin : g_chk_x_in
      assign w_chk_x = w_xe[CHK_SHIFT];
    end else begin : g_chk_x_out
      assign w_chk_x = 1'b0;
    end

    if (CHK_SHIFT < c_YW) begin : g_chk_y_in
      assign w_chk_y = r_y[CHK_SHIFT];
    end else begin : g_chk_y_out
      assign w_chk_y = 1'b0;
    end
  endgenerate

  always_comb begin
    w_bar_rgb = 16'h0000;
    case (r_bar_idx)
      3'd0:    w_bar_rgb = 16'hFFFF;
      3'd1:    w_bar_rgb = 16'hFFE0;
      3'd2:    w_bar_rgb = 16'h07FF;
      3'd3:    w_bar_rgb = 16'h07E0;
      3'd4:    w_bar_rgb = 16'hF81F;
      3'd5:    w_bar_rgb = 16'hF800;
      3'd6:    w_bar_rgb = 16'h001F;
      default: w_bar_rgb = 16'h0000;
    endcase
  end

  always_comb begin
    w_pix = r_color;
    case (r_mode)
      2'd0:    w_pix = w_bar_rgb;
      2'd1:    w_pix = {w_ramp_v[5:1], w_ramp_v, w_ramp_v[5:1]};
      2'd2:    w_pix = (w_chk_x ^ w_chk_y) ? 16'hFFFF : 16'h0000;
      default: w_pix = r_color;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_bar_idx_nxt    = r_bar_idx;
    w_bar_off_nxt    = r_bar_off;
    w_mode_nxt       = r_mode;
    w_color_nxt      = r_color;
    w_data_en_nxt    = 1'b0;
    w_dout_nxt       = r_dout;
    w_frame_done_nxt = 1'b0;
`ifdef VGA_PATTERN_SCROLL_EN
    w_xe_nxt         = r_xe;
`endif
    case (r_state)
      S_IDLE: begin
        // A start coinciding with the done pulse belongs to the old frame
        if (bus.start_i && !r_frame_done) begin
          w_mode_nxt    = bus.mode_i;
          w_color_nxt   = bus.color_i;
          w_x_nxt       = '0;
          w_y_nxt       = '0;
          w_bar_idx_nxt = w_pre_idx;
          w_bar_off_nxt = w_pre_off;
`ifdef VGA_PATTERN_SCROLL_EN
          w_xe_nxt      = w_pre_x;
`endif
          w_state_nxt   = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.wr_en) begin
          w_data_en_nxt = 1'b1;
          w_dout_nxt    = DATA_W'(w_pix);
          if (r_x == c_X_LAST) begin
            w_x_nxt       = '0;
            w_y_nxt       = r_y + 1'b1;
            w_bar_idx_nxt = w_pre_idx;
            w_bar_off_nxt = w_pre_off;
`ifdef VGA_PATTERN_SCROLL_EN
            w_xe_nxt      = w_pre_x;
`endif
            if (r_y == c_Y_LAST) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_x_nxt = r_x + 1'b1;
`ifdef VGA_PATTERN_SCROLL_EN
            w_xe_nxt = (r_xe == c_X_LAST) ? '0 : r_xe + 1'b1;
`endif
            if (w_xe == c_X_LAST) begin
              w_bar_idx_nxt = '0;
              w_bar_off_nxt = '0;
            end else if (r_bar_off == c_BAR_LAST) begin
              w_bar_idx_nxt = r_bar_idx + 3'd1;
              w_bar_off_nxt = '0;
            end else begin
              w_bar_off_nxt = r_bar_off + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        w_frame_done_nxt = 1'b1;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_bar_idx    <= '0;
      r_bar_off    <= '0;
      r_mode       <= '0;
      r_color      <= '0;
      r_data_en    <= 1'b0;
      r_dout       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_bar_idx    <= w_bar_idx_nxt;
      r_bar_off    <= w_bar_off_nxt;
      r_mode       <= w_mode_nxt;
      r_color      <= w_color_nxt;
      r_data_en    <= w_data_en_nxt;
      r_dout       <= w_dout_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign bus.data_en      = r_data_en;
  assign bus.dout         = r_dout;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.frame_done_o = r_frame_done;

endmodule
`default_nettype wire
